// File: rtl/gamma_pixel_scheduler_pkg.sv
// Shared types and constants for the LED-strip pixel pipeline (package music_strip_pkg).
package music_strip_pkg;

  localparam int PIXEL_W = 24;
  localparam int G_MSB   = 23;
  localparam int R_MSB   = 15;
  localparam int B_MSB   = 7;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    WAIT,
    CH_G,
    CH_R,
    CH_B,
    PRESENT,
    DONE
  } sched_state_e;

  // Selects the colour byte that the given channel state feeds into the shared LUT.
  function automatic logic [7:0] channel_byte(input sched_state_e st,
                                              input logic [PIXEL_W-1:0] px);
    logic [7:0] sel;
    case (st)
      CH_G:    sel = px[G_MSB -: 8];
      CH_R:    sel = px[R_MSB -: 8];
      CH_B:    sel = px[B_MSB -: 8];
      default: sel = 8'd0;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/gamma_pixel_scheduler_lut.sv
// Combinational gamma (~2.0) curve: out = round(in*in/255), so 0 maps to 0 and 255 to 255.
module gamma_correction_LUT (
  input  logic [7:0] lut_in,
  output logic [7:0] lut_out
);

  logic [15:0] square_s;

  // Square the input and rescale with round-to-nearest.
  always_comb begin
    square_s = {8'd0, lut_in} * {8'd0, lut_in};
    lut_out  = 8'((square_s + 16'd127) / 16'd255);
  end

endmodule

// File: rtl/gamma_pixel_scheduler.sv
// Fetches one GRB pixel at a time, gamma-corrects each byte through one shared LUT and
// presents it on a valid/ready port. Build option GAMMA_BYPASS_EN adds a raw-copy bypass.
module gamma_pixel_scheduler
  import music_strip_pkg::*;
#(
  parameter int NUM_LEDS = 60,
  parameter int ADDR_W   = 10
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               frame_start,
`ifdef GAMMA_BYPASS_EN
  input  logic               gamma_bypass,
`endif
  output logic               pix_rd_en,
  output logic [ADDR_W-1:0]  pix_addr,
  input  logic [PIXEL_W-1:0] pix_data,
  output logic [PIXEL_W-1:0] out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               busy,
  output logic               frame_done
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_LEDS - 1);
  localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);

  sched_state_e       state_r;
  logic [ADDR_W-1:0]  pix_addr_r;
  logic               pix_rd_en_r;
  logic [PIXEL_W-1:0] pixel_r;
  logic [PIXEL_W-1:0] out_data_r;
  logic               out_valid_r;
  logic               busy_r;
  logic               frame_done_r;
  logic [7:0]         lut_in_s;
  logic [7:0]         lut_out_s;
  logic [7:0]         ch_byte_s;

  assign lut_in_s = channel_byte(state_r, pixel_r);

  gamma_correction_LUT u_gamma_lut (
    .lut_in  (lut_in_s),
    .lut_out (lut_out_s)
  );

`ifdef GAMMA_BYPASS_EN
  logic bypass_r;

  // Bypass is frozen for the whole frame at the moment the frame is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bypass_r <= 1'b0;
    end else if (state_r == IDLE && frame_start) begin
      bypass_r <= gamma_bypass;
    end
  end

  // Channel result: raw byte when bypassed, LUT output otherwise.
  always_comb begin
    ch_byte_s = lut_out_s;
    if (bypass_r) begin
      ch_byte_s = lut_in_s;
    end else begin
      ch_byte_s = lut_out_s;
    end
  end
`else
  assign ch_byte_s = lut_out_s;
`endif

  // Frame sequencing FSM; every output is a register updated on the state transitions.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      pix_addr_r   <= '0;
      pix_rd_en_r  <= 1'b0;
      pixel_r      <= '0;
      out_data_r   <= '0;
      out_valid_r  <= 1'b0;
      busy_r       <= 1'b0;
      frame_done_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (frame_start) begin
            state_r     <= FETCH;
            pix_addr_r  <= '0;
            pix_rd_en_r <= 1'b1;
            busy_r      <= 1'b1;
          end
        end
        FETCH: begin
          pix_rd_en_r <= 1'b0;
          state_r     <= WAIT;
        end
        WAIT: begin
          pixel_r <= pix_data;
          state_r <= CH_G;
        end
        CH_G: begin
          out_data_r[G_MSB -: 8] <= ch_byte_s;
          state_r                <= CH_R;
        end
        CH_R: begin
          out_data_r[R_MSB -: 8] <= ch_byte_s;
          state_r                <= CH_B;
        end
        CH_B: begin
          out_data_r[B_MSB -: 8] <= ch_byte_s;
          out_valid_r            <= 1'b1;
          state_r                <= PRESENT;
        end
        PRESENT: begin
          // The last pixel ends the frame instead of advancing, so the address never wraps.
          if (out_ready) begin
            out_valid_r <= 1'b0;
            if (pix_addr_r == LAST_ADDR) begin
              frame_done_r <= 1'b1;
              state_r      <= DONE;
            end else begin
              pix_addr_r  <= pix_addr_r + ADDR_ONE;
              pix_rd_en_r <= 1'b1;
              state_r     <= FETCH;
            end
          end
        end
        DONE: begin
          frame_done_r <= 1'b0;
          busy_r       <= 1'b0;
          state_r      <= IDLE;
        end
        default: begin
          state_r      <= IDLE;
          pix_rd_en_r  <= 1'b0;
          out_valid_r  <= 1'b0;
          busy_r       <= 1'b0;
          frame_done_r <= 1'b0;
        end
      endcase
    end
  end

  assign pix_rd_en  = pix_rd_en_r;
  assign pix_addr   = pix_addr_r;
  assign out_data   = out_data_r;
  assign out_valid  = out_valid_r;
  assign busy       = busy_r;
  assign frame_done = frame_done_r;

endmodule
